load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 60 ++++++
 rtl/load_extend.sv | 32 +++
 rtl/load_store_unit.sv | 112 +++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : FSM states, Funct3 encodings and access helpers for the LSU.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_illegal(input logic [2:0] f3,
                                      input logic [1:0] off,
                                      input logic       store);
    logic bad;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    // Unsigned encodings have no store counterpart
    if (store && f3[2]) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Selects the addressed lane of a read word and sign/zero-extends.
// Revision : 1.0
// ============================================================================
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  Funct3,
  output logic [31:0] result
);

  logic [31:0] w_lane;

  assign w_lane = rdata >> {offset, 3'b000};

  always_comb begin
    result = rdata;
    case (Funct3)
      F3_B:    result = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_H:    result = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_BU:   result = {24'd0, w_lane[7:0]};
      F3_HU:   result = {16'd0, w_lane[15:0]};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding load/store bridge between pipeline and bus.
// Revision : 1.0
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignedFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        w_access;
  logic        w_illegal;
  logic        w_start;
  logic        w_load_done;
  logic [31:0] w_ext;

  // Gated by reset so Stall/MisalignedFault stay low while reset is held
  assign w_access    = reset & (MemRead | MemWrite);
  assign w_illegal   = is_illegal(Funct3, ALUResult[1:0], MemWrite);
  assign w_start     = (r_state == IDLE) && w_access && !w_illegal;
  assign w_load_done = ((r_state == REQ) && mem_gnt && mem_rvalid && !mem_we) ||
                       ((r_state == WAIT) && mem_rvalid);

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .offset (r_off),
    .Funct3 (r_f3),
    .result (w_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = REQ;
      REQ: begin
        if (mem_gnt) begin
          if (mem_we || mem_rvalid) w_next = DONE;
          else                      w_next = WAIT;
        end
      end
      WAIT:    if (mem_rvalid) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req         = (r_state == REQ);
    Stall           = (r_state == REQ) || (r_state == WAIT) || w_start;
    MisalignedFault = (r_state == IDLE) && w_access && w_illegal;
  end

  // Bus fields are frozen at acceptance so they stay stable through REQ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      r_f3      <= 3'd0;
      r_off     <= 2'd0;
    end else if (w_start) begin
      mem_we    <= MemWrite;
      mem_addr  <= {ALUResult[31:2], 2'b00};
      mem_be    <= byte_enables(Funct3, ALUResult[1:0]);
      mem_wdata <= store_data(Funct3, WriteData);
      r_f3      <= Funct3;
      r_off     <= ALUResult[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData <= 32'd0;
    end else if (w_load_done) begin
      ReadData <= w_ext;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed, table-driven self-checking bench for load_store_unit.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, MisalignedFault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rd_last = 32'd0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[16];

  load_store_unit dut (
    .clk             (clk),
    .reset           (reset),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Funct3          (Funct3),
    .ALUResult       (ALUResult),
    .WriteData       (WriteData),
    .ReadData        (ReadData),
    .Stall           (Stall),
    .MisalignedFault (MisalignedFault),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int gd, input int rvd,
                              input logic [31:0] rdata, input logic fault,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.gnt_dly = gd; v.rv_dly = rvd; v.rdata = rdata; v.fault = fault;
    v.e_addr = ea; v.e_be = ebe; v.e_wdata = ewd; v.e_rdata = erd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
    ALUResult = v.addr; WriteData = v.wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    if (v.fault) begin
      check({v.name, ".fault"}, 32'(MisalignedFault), 32'd1);
      check({v.name, ".stall"}, 32'(Stall), 32'd0);
      check({v.name, ".req"},   32'(mem_req), 32'd0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      check({v.name, ".fault_end"}, 32'(MisalignedFault), 32'd0);
      check({v.name, ".req_after"}, 32'(mem_req), 32'd0);
      return;
    end
    check({v.name, ".stall_idle"}, 32'(Stall), 32'd1);
    check({v.name, ".req_idle"},   32'(mem_req), 32'd0);
    check({v.name, ".nofault"},    32'(MisalignedFault), 32'd0);
    for (int k = 0; k <= v.gnt_dly; k++) begin
      @(posedge clk); #1;
      if (k == v.gnt_dly) begin
        mem_gnt = 1'b1;
        // stores also see a stray rvalid here, which must be ignored
        if (v.wr || v.rv_dly == 0) begin
          mem_rvalid = 1'b1; mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      check({v.name, ".req"},   32'(mem_req), 32'd1);
      check({v.name, ".stall"}, 32'(Stall), 32'd1);
      check({v.name, ".addr"},  mem_addr, v.e_addr);
      check({v.name, ".we"},    32'(mem_we), 32'(v.wr));
      if (v.wr) begin
        check({v.name, ".be"},    32'(mem_be), 32'(v.e_be));
        check({v.name, ".wdata"}, mem_wdata, v.e_wdata);
      end
    end
    if (!v.wr) begin
      for (int k = 1; k <= v.rv_dly; k++) begin
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        if (k == v.rv_dly) begin
          mem_rvalid = 1'b1; mem_rdata = v.rdata;
        end
        @(negedge clk);
        check({v.name, ".wait_req"},   32'(mem_req), 32'd0);
        check({v.name, ".wait_stall"}, 32'(Stall), 32'd1);
      end
      exp_rd_last = v.e_rdata;
    end
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A5A5A;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check({v.name, ".stall_done"}, 32'(Stall), 32'd0);
    check({v.name, ".req_done"},   32'(mem_req), 32'd0);
    check({v.name, ".rdata"},      ReadData, exp_rd_last);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    @(negedge clk);
    check({v.name, ".stall_idle2"}, 32'(Stall), 32'd0);
    check({v.name, ".rdata_hold"},  ReadData, exp_rd_last);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk("sw_100",  0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'hBAD0BAD0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 0);
    vecs[1]  = mk("lb_103",  1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80FF1234, 0, 32'h100, 0, 0, 32'hFFFFFF80);
    vecs[2]  = mk("lbu_103", 1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80FF1234, 0, 32'h100, 0, 0, 32'h00000080);
    vecs[3]  = mk("sh_202",  0, 1, 3'b001, 32'h202, 32'h0000ABCD, 3, 0, 32'hBAD0BAD0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 0);
    vecs[4]  = mk("lw_101",  1, 0, 3'b010, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mk("lh_000",  1, 0, 3'b001, 32'h000, 0, 0, 5, 32'h00007FFF, 0, 32'h000, 0, 0, 32'h00007FFF);
    vecs[6]  = mk("sb_001",  0, 1, 3'b000, 32'h001, 32'h12345678, 1, 0, 32'hBAD0BAD0, 0, 32'h000, 4'b0010, 32'h78787878, 0);
    vecs[7]  = mk("lhu_002", 1, 0, 3'b101, 32'h002, 0, 1, 1, 32'h8001FFFF, 0, 32'h000, 0, 0, 32'h00008001);
    vecs[8]  = mk("lh_002",  1, 0, 3'b001, 32'h002, 0, 0, 2, 32'h8001FFFF, 0, 32'h000, 0, 0, 32'hFFFF8001);
    vecs[9]  = mk("lw_004",  1, 0, 3'b010, 32'h004, 0, 2, 0, 32'hCAFEF00D, 0, 32'h004, 0, 0, 32'hCAFEF00D);
    vecs[10] = mk("sh_001",  0, 1, 3'b001, 32'h001, 32'h1111, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk("f3_011",  1, 0, 3'b011, 32'h000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk("sbu",     0, 1, 3'b100, 32'h000, 32'h22, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[13] = mk("rdwr_sw", 1, 1, 3'b010, 32'h008, 32'h11223344, 0, 0, 32'hBAD0BAD0, 0, 32'h008, 4'b1111, 32'h11223344, 0);
    vecs[14] = mk("lb_001",  1, 0, 3'b000, 32'h001, 0, 1, 3, 32'h00007F00, 0, 32'h000, 0, 0, 32'h0000007F);
    vecs[15] = mk("f3_110",  1, 0, 3'b110, 32'h004, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    reset = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h101;
    WriteData = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.stall", 32'(Stall), 32'd0);
    check("rst.fault", 32'(MisalignedFault), 32'd0);
    check("rst.req",   32'(mem_req), 32'd0);
    check("rst.we",    32'(mem_we), 32'd0);
    check("rst.addr",  mem_addr, 32'd0);
    check("rst.be",    32'(mem_be), 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    check("rst.rdata", ReadData, 32'd0);
    MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during WAIT abandons the load; a late response must be ignored
    @(posedge clk); #1;
    MemRead = 1'b1; Funct3 = 3'b001; ALUResult = 32'h010;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check("wrst.wait_stall", 32'(Stall), 32'd1);
    #1;
    reset = 1'b0; MemRead = 1'b0;
    #1;
    check("wrst.stall", 32'(Stall), 32'd0);
    check("wrst.rdata", ReadData, 32'd0);
    check("wrst.addr",  mem_addr, 32'd0);
    check("wrst.be",    32'(mem_be), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678; mem_gnt = 1'b1;
    @(negedge clk);
    check("wrst.stray_stall", 32'(Stall), 32'd0);
    check("wrst.stray_req",   32'(mem_req), 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    check("wrst.rdata_after", ReadData, 32'd0);
    check("wrst.req_after",   32'(mem_req), 32'd0);
    check("wrst.stall_after", 32'(Stall), 32'd0);
    exp_rd_last = 32'd0;

    run_vec(mk("lw_recover", 1, 0, 3'b010, 32'h00C, 0, 0, 1, 32'h0BADF00D, 0, 32'h00C, 0, 0, 32'h0BADF00D));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
